// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg
// Shared definitions for the core's inter-stage pipeline registers:
//   - pipe_state_e : occupancy state of a pipe_stage_reg (EMPTY/ONE/TWO)
//   - payload field offsets/widths for the ID/EX and EX/MEM payloads, so that
//     the producing and consuming stage pack and unpack identically.
// The register-write enable is stored active-high (the inverse of GPRWE_),
// so an all-zero payload is a NOP: no register write, no exception.
package cpu_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    // ID/EX payload layout
    localparam int IDEX_ALU_OP_LSB = 0;   localparam int IDEX_ALU_OP_W = 5;
    localparam int IDEX_OPA_LSB    = 5;   localparam int IDEX_OPA_W    = 32;
    localparam int IDEX_OPB_LSB    = 37;  localparam int IDEX_OPB_W    = 32;
    localparam int IDEX_MEM_OP_LSB = 69;  localparam int IDEX_MEM_OP_W = 3;
    localparam int IDEX_DST_LSB    = 72;  localparam int IDEX_DST_W    = 5;
    localparam int IDEX_GPRWE_LSB  = 77;  localparam int IDEX_GPRWE_W  = 1;
    localparam int IDEX_EXC_LSB    = 78;  localparam int IDEX_EXC_W    = 4;
    localparam int IDEX_USED_W     = 82;

    // EX/MEM payload layout
    localparam int EXMEM_RESULT_LSB = 0;  localparam int EXMEM_RESULT_W = 32;
    localparam int EXMEM_STDATA_LSB = 32; localparam int EXMEM_STDATA_W = 32;
    localparam int EXMEM_MEM_OP_LSB = 64; localparam int EXMEM_MEM_OP_W = 3;
    localparam int EXMEM_DST_LSB    = 67; localparam int EXMEM_DST_W    = 5;
    localparam int EXMEM_GPRWE_LSB  = 72; localparam int EXMEM_GPRWE_W  = 1;
    localparam int EXMEM_EXC_LSB    = 73; localparam int EXMEM_EXC_W    = 4;
    localparam int EXMEM_USED_W     = 77;

    // Number of held entries for a given occupancy state.
    function automatic logic [1:0] state_count(pipe_state_e st);
        case (st)
            ST_ONE:  return 2'd1;
            ST_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg
// One pipeline entry: PC + payload + valid flag, with clear and load enables.
// Clear has priority over load. A cleared (or reset) entry shows PC=0 and
// NOP_PAYLOAD so downstream sees a clean bubble.
// Ports:
//   clk, reset_          clock, asynchronous active-low reset
//   clear_i              invalidate the entry
//   load_i               capture pc_i/payload_i and mark valid
//   pc_i, payload_i      entry to load
//   valid_o, pc_o, payload_o  held entry
module pipe_entry_reg #(
    parameter int                   PC_W        = 30,
    parameter int                   PAYLOAD_W   = 128,
    parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0
) (
    input  logic                 clk,
    input  logic                 reset_,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic [PC_W-1:0]      pc_i,
    input  logic [PAYLOAD_W-1:0] payload_i,
    output logic                 valid_o,
    output logic [PC_W-1:0]      pc_o,
    output logic [PAYLOAD_W-1:0] payload_o
);

    logic                 valid_q;
    logic [PC_W-1:0]      pc_q;
    logic [PAYLOAD_W-1:0] payload_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            payload_q <= NOP_PAYLOAD;
        end else if (clear_i) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            payload_q <= NOP_PAYLOAD;
        end else if (load_i) begin
            valid_q   <= 1'b1;
            pc_q      <= pc_i;
            payload_q <= payload_i;
        end
    end

    assign valid_o   = valid_q;
    assign pc_o      = pc_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Elastic inter-stage pipeline register carrying PC + opaque payload with a
// valid/ready handshake under global Stall/Flush control.
// Priority: reset_ > Stall > Flush > normal transfer.
// Build option PIPE_STAGE_SKID_EN: when defined, a second (skid) entry lets
// InReady come straight from a register (no path from OutReady) and Count
// ranges 0..2. When undefined, a single entry is used, InReady depends
// combinationally on OutReady, and Count[1] is always 0.
// Ports:
//   clk, reset_            clock, asynchronous active-low reset
//   Stall, Flush           global freeze / discard-all
//   InValid, InReady       upstream handshake
//   InPC, InPayload        upstream entry
//   OutValid, OutReady     downstream handshake
//   OutPC, OutPayload      head entry (0 / NOP_PAYLOAD when empty)
//   Count                  number of held entries
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int                   PC_W        = 30,
    parameter int                   PAYLOAD_W   = 128,
    parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = {PAYLOAD_W{1'b0}}
) (
    input  logic                 clk,
    input  logic                 reset_,
    input  logic                 Stall,
    input  logic                 Flush,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [PC_W-1:0]      InPC,
    input  logic [PAYLOAD_W-1:0] InPayload,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [PC_W-1:0]      OutPC,
    output logic [PAYLOAD_W-1:0] OutPayload,
    output logic [1:0]           Count
);

    logic                 accept;
    logic                 consume;
    logic                 main_load;
    logic                 main_clear;
    logic [PC_W-1:0]      main_pc_d;
    logic [PAYLOAD_W-1:0] main_payload_d;

    assign accept  = InValid & InReady;
    assign consume = OutValid & OutReady & ~Stall;

    pipe_entry_reg #(
        .PC_W        (PC_W),
        .PAYLOAD_W   (PAYLOAD_W),
        .NOP_PAYLOAD (NOP_PAYLOAD)
    ) u_main (
        .clk       (clk),
        .reset_    (reset_),
        .clear_i   (main_clear),
        .load_i    (main_load),
        .pc_i      (main_pc_d),
        .payload_i (main_payload_d),
        .valid_o   (OutValid),
        .pc_o      (OutPC),
        .payload_o (OutPayload)
    );

`ifdef PIPE_STAGE_SKID_EN
    pipe_state_e          state_q, state_d;
    logic                 skid_load;
    logic                 skid_clear;
    logic                 skid_valid;
    logic [PC_W-1:0]      skid_pc;
    logic [PAYLOAD_W-1:0] skid_payload;

    pipe_entry_reg #(
        .PC_W        (PC_W),
        .PAYLOAD_W   (PAYLOAD_W),
        .NOP_PAYLOAD (NOP_PAYLOAD)
    ) u_skid (
        .clk       (clk),
        .reset_    (reset_),
        .clear_i   (skid_clear),
        .load_i    (skid_load),
        .pc_i      (InPC),
        .payload_i (InPayload),
        .valid_o   (skid_valid),
        .pc_o      (skid_pc),
        .payload_o (skid_payload)
    );

    // NOTE: every always_comb output gets a default first, so no path through
    // the case/if tree can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_pc_d      = InPC;
        main_payload_d = InPayload;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (!Stall) begin
            if (Flush) begin
                main_clear = 1'b1;
                skid_clear = 1'b1;
                state_d    = ST_EMPTY;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (accept) begin
                            main_load = 1'b1;
                            state_d   = ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (accept && !consume) begin
                            skid_load = 1'b1;
                            state_d   = ST_TWO;
                        end else if (accept && consume) begin
                            main_load = 1'b1;
                        end else if (consume) begin
                            main_clear = 1'b1;
                            state_d    = ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        // InReady is low in TWO, so only the head can move.
                        if (consume) begin
                            main_load      = 1'b1;
                            main_pc_d      = skid_pc;
                            main_payload_d = skid_payload;
                            skid_clear     = 1'b1;
                            state_d        = ST_ONE;
                        end
                    end
                    default: state_d = ST_EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) state_q <= ST_EMPTY;
        else         state_q <= state_d;
    end

    // Registered state only: OutReady never reaches InReady.
    assign InReady = reset_ & (state_q != ST_TWO) & ~Stall & ~Flush;
    assign Count   = state_count(state_q);

    // skid_valid mirrors state_q == ST_TWO; kept for debug visibility.
    logic unused_skid_valid;
    assign unused_skid_valid = skid_valid;
`else
    // Single entry: a consumed head may be replaced by a new entry in the same
    // cycle, which keeps full throughput at the cost of a combinational
    // OutReady -> InReady path.
    assign main_pc_d      = InPC;
    assign main_payload_d = InPayload;
    assign main_load      = accept;
    assign main_clear     = (Flush & ~Stall) | (consume & ~accept);

    assign InReady = reset_ & (~OutValid | OutReady) & ~Stall & ~Flush;
    assign Count   = {1'b0, OutValid};
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
// Self-checking bench for pipe_stage_reg. A queue-based reference model
// (capacity 2 with PIPE_STAGE_SKID_EN, 1 without) predicts every output.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled 3 units after the rising edge.
module tb_pipe_stage_reg;

    localparam int PC_W      = 30;
    localparam int PAYLOAD_W = 128;
    localparam logic [PAYLOAD_W-1:0] TB_NOP = 128'h0000_C0DE_0000_0000_0000_0000_8001_0000;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic                 clk;
    logic                 reset_;
    logic                 Stall;
    logic                 Flush;
    logic                 InValid;
    logic                 InReady;
    logic [PC_W-1:0]      InPC;
    logic [PAYLOAD_W-1:0] InPayload;
    logic                 OutValid;
    logic                 OutReady;
    logic [PC_W-1:0]      OutPC;
    logic [PAYLOAD_W-1:0] OutPayload;
    logic [1:0]           Count;

    pipe_stage_reg #(
        .PC_W        (PC_W),
        .PAYLOAD_W   (PAYLOAD_W),
        .NOP_PAYLOAD (TB_NOP)
    ) dut (
        .clk        (clk),
        .reset_     (reset_),
        .Stall      (Stall),
        .Flush      (Flush),
        .InValid    (InValid),
        .InReady    (InReady),
        .InPC       (InPC),
        .InPayload  (InPayload),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .OutPC      (OutPC),
        .OutPayload (OutPayload),
        .Count      (Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [PAYLOAD_W-1:0] pl;
    } ent_t;

    ent_t            mq[$];       // held entries, head first
    logic [PC_W-1:0] out_log[$];  // PCs consumed downstream, in order

    function automatic logic exp_ready();
        if (!reset_ || Stall || Flush) return 1'b0;
        if (CAP == 2) return mq.size() < 2;
        return (mq.size() == 0) || OutReady;
    endfunction

    function automatic logic exp_valid();
        return mq.size() != 0;
    endfunction

    function automatic logic [PC_W-1:0] exp_pc();
        return (mq.size() != 0) ? mq[0].pc : '0;
    endfunction

    function automatic logic [PAYLOAD_W-1:0] exp_pl();
        return (mq.size() != 0) ? mq[0].pl : TB_NOP;
    endfunction

    function automatic logic [1:0] exp_count();
        return 2'(mq.size());
    endfunction

    // Advance one clock edge and update the model from the inputs in force.
    task automatic tick();
        logic acc, con;
        ent_t e;
        acc = InValid && exp_ready();
        con = exp_valid() && OutReady && !Stall;
        e   = {InPC, InPayload};
        @(posedge clk);
        #1;
        if (!reset_ || Stall) begin
            if (!reset_) mq.delete();
        end else if (Flush) begin
            mq.delete();
        end else begin
            if (con) begin
                out_log.push_back(mq[0].pc);
                void'(mq.pop_front());
            end
            if (acc) mq.push_back(e);
        end
    endtask

    function automatic logic [PAYLOAD_W-1:0] rnd_pl();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_    = 1'b0;
        Stall     = 1'b0;
        Flush     = 1'b0;
        InValid   = 1'b1;
        InPC      = 30'h100;
        InPayload = rnd_pl();
        OutReady  = 1'b0;
        mq.delete();
        repeat (2) @(posedge clk);
        #3;
        n_checks++; if (OutValid !== 1'b0) $display("FAIL reset_outvalid got=%b exp=0", OutValid); else n_pass++;
        n_checks++; if (OutPayload !== TB_NOP) $display("FAIL reset_payload got=%h exp=%h", OutPayload, TB_NOP); else n_pass++;
        n_checks++; if (OutPC !== '0) $display("FAIL reset_pc got=%h exp=0", OutPC); else n_pass++;
        n_checks++; if (Count !== 2'd0) $display("FAIL reset_count got=%0d exp=0", Count); else n_pass++;
        n_checks++; if (InReady !== 1'b0) $display("FAIL reset_inready got=%b exp=0", InReady); else n_pass++;
        @(negedge clk);
        reset_  = 1'b1;
        InValid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_streaming();
        InValid  = 1'b1;
        OutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            InValid   = (i < 3);
            InPC      = 30'h10 + 30'(i);
            InPayload = rnd_pl();
            #2;
            if (i > 0) begin
                n_checks++; if (OutPC !== 30'h10 + 30'(i - 1)) $display("FAIL stream_pc[%0d] got=%h exp=%h", i, OutPC, 30'h10 + 30'(i - 1)); else n_pass++;
                n_checks++; if (OutPayload !== exp_pl()) $display("FAIL stream_payload[%0d] got=%h exp=%h", i, OutPayload, exp_pl()); else n_pass++;
                n_checks++; if (Count !== 2'd1) $display("FAIL stream_count[%0d] got=%0d exp=1", i, Count); else n_pass++;
                n_checks++; if (InReady !== 1'b1) $display("FAIL stream_inready[%0d] got=%b exp=1", i, InReady); else n_pass++;
            end
            tick();
        end
        InValid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int maxcnt = 0;
        InValid  = 1'b0;
        OutReady = 1'b1;
        tick();
        out_log.delete();
        for (int cyc = 0; cyc < 12; cyc++) begin
            OutReady  = (cyc == 0) || (cyc >= 5);
            InValid   = (idx < 3);
            InPC      = 30'h20 + 30'(idx);
            InPayload = rnd_pl();
            #2;
            if (int'(Count) > maxcnt) maxcnt = int'(Count);
            n_checks++; if (InReady !== exp_ready()) $display("FAIL bp_inready[%0d] got=%b exp=%b", cyc, InReady, exp_ready()); else n_pass++;
            n_checks++; if (OutPC !== exp_pc()) $display("FAIL bp_pc[%0d] got=%h exp=%h", cyc, OutPC, exp_pc()); else n_pass++;
            if (cyc == 3) begin
                n_checks++; if (Count !== 2'(CAP)) $display("FAIL bp_full_count got=%0d exp=%0d", Count, CAP); else n_pass++;
                n_checks++; if (InReady !== 1'b0) $display("FAIL bp_full_inready got=%b exp=0", InReady); else n_pass++;
            end
            if (InValid && exp_ready()) idx++;
            tick();
        end
        n_checks++; if (maxcnt != CAP) $display("FAIL bp_max_count got=%0d exp=%0d", maxcnt, CAP); else n_pass++;
        n_checks++;
        if (out_log.size() != 3) $display("FAIL bp_out_count got=%0d exp=3", out_log.size());
        else if (out_log[0] !== 30'h20 || out_log[1] !== 30'h21 || out_log[2] !== 30'h22)
            $display("FAIL bp_out_order got=%h,%h,%h exp=20,21,22", out_log[0], out_log[1], out_log[2]);
        else n_pass++;
    endtask

    task automatic test_stall_flush();
        logic [PC_W-1:0] saved_pc;
        OutReady = 1'b0;
        InValid  = 1'b1;
        for (int i = 0; i < CAP + 1; i++) begin
            InPC      = 30'($urandom);
            InPayload = rnd_pl();
            tick();
        end
        InValid  = 1'b0;
        saved_pc = exp_pc();
        Stall    = 1'b1;
        Flush    = 1'b1;
        OutReady = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2;
            n_checks++; if (Count !== 2'(CAP)) $display("FAIL stall_count[%0d] got=%0d exp=%0d", i, Count, CAP); else n_pass++;
            n_checks++; if (OutPC !== saved_pc) $display("FAIL stall_pc[%0d] got=%h exp=%h", i, OutPC, saved_pc); else n_pass++;
            n_checks++; if (InReady !== 1'b0) $display("FAIL stall_inready[%0d] got=%b exp=0", i, InReady); else n_pass++;
            tick();
        end
        Stall = 1'b0;
        #2;
        n_checks++; if (InReady !== 1'b0) $display("FAIL flush_inready got=%b exp=0", InReady); else n_pass++;
        tick();
        Flush = 1'b0;
        #2;
        n_checks++; if (Count !== 2'd0) $display("FAIL flush_count got=%0d exp=0", Count); else n_pass++;
        n_checks++; if (OutValid !== 1'b0) $display("FAIL flush_outvalid got=%b exp=0", OutValid); else n_pass++;
        n_checks++; if (OutPC !== '0) $display("FAIL flush_pc got=%h exp=0", OutPC); else n_pass++;
        n_checks++; if (OutPayload !== TB_NOP) $display("FAIL flush_payload got=%h exp=%h", OutPayload, TB_NOP); else n_pass++;
        tick();
    endtask

    task automatic test_flush_input();
        OutReady  = 1'b0;
        InValid   = 1'b1;
        InPC      = 30'h2F;
        InPayload = rnd_pl();
        tick();
        Flush     = 1'b1;
        InPC      = 30'h30;
        #2;
        n_checks++; if (InReady !== 1'b0) $display("FAIL flushin_inready got=%b exp=0", InReady); else n_pass++;
        tick();
        Flush   = 1'b0;
        InValid = 1'b0;
        #2;
        n_checks++; if (OutValid !== 1'b0) $display("FAIL flushin_outvalid got=%b exp=0", OutValid); else n_pass++;
        n_checks++; if (Count !== 2'd0) $display("FAIL flushin_count got=%0d exp=0", Count); else n_pass++;
        tick();
    endtask

    task automatic test_async_reset();
        OutReady = 1'b0;
        InValid  = 1'b1;
        for (int i = 0; i < CAP; i++) begin
            InPC      = 30'($urandom);
            InPayload = rnd_pl();
            tick();
        end
        InValid = 1'b0;
        #3;
        reset_ = 1'b0;
        mq.delete();
        #1;
        n_checks++; if (OutValid !== 1'b0) $display("FAIL areset_outvalid got=%b exp=0", OutValid); else n_pass++;
        n_checks++; if (Count !== 2'd0) $display("FAIL areset_count got=%0d exp=0", Count); else n_pass++;
        n_checks++; if (OutPayload !== TB_NOP) $display("FAIL areset_payload got=%h exp=%h", OutPayload, TB_NOP); else n_pass++;
        n_checks++; if (InReady !== 1'b0) $display("FAIL areset_inready got=%b exp=0", InReady); else n_pass++;
        #2;
        reset_ = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            Stall     = ($urandom % 10) == 0;
            Flush     = ($urandom % 16) == 0;
            InValid   = ($urandom % 10) < 7;
            OutReady  = ($urandom % 10) < 6;
            InPC      = 30'($urandom);
            InPayload = rnd_pl();
            #2;
            n_checks++; if (InReady !== exp_ready()) $display("FAIL rand_inready[%0d] got=%b exp=%b", cyc, InReady, exp_ready()); else n_pass++;
            n_checks++; if (OutValid !== exp_valid()) $display("FAIL rand_outvalid[%0d] got=%b exp=%b", cyc, OutValid, exp_valid()); else n_pass++;
            n_checks++; if (OutPC !== exp_pc()) $display("FAIL rand_pc[%0d] got=%h exp=%h", cyc, OutPC, exp_pc()); else n_pass++;
            n_checks++; if (OutPayload !== exp_pl()) $display("FAIL rand_payload[%0d] got=%h exp=%h", cyc, OutPayload, exp_pl()); else n_pass++;
            n_checks++; if (Count !== exp_count()) $display("FAIL rand_count[%0d] got=%0d exp=%0d", cyc, Count, exp_count()); else n_pass++;
            tick();
        end
        Stall   = 1'b0;
        Flush   = 1'b0;
        InValid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_stall_flush();
        test_flush_input();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d passed=%0d", n_checks, n_pass);
        $fatal(1, "watchdog");
    end

endmodule
